// File: rtl/kds_ctrl.sv
// kds_ctrl: load-then-run controller for a kernel store built from NB_BLOCKS
// groups of three FIFOs. LOAD streams kernel triplets into the store one block
// at a time. RUN rotates every FIFO one entry per permitted step.
// Optional feature macro: KDS_CTRL_RERUN_EN. It adds a rerun input that restarts
// RUN on an already loaded kernel without reloading it.
module kds_ctrl #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NB_BLOCKS     = 12,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          srst_in,
  input  logic                          start,
  input  logic [15:0]                   nb_steps,
  input  logic [IO_DATA_WIDTH-1:0]      k_data_1,
  input  logic [IO_DATA_WIDTH-1:0]      k_data_2,
  input  logic [IO_DATA_WIDTH-1:0]      k_data_3,
  input  logic                          k_valid,
  output logic                          k_ready,
  output logic [IO_DATA_WIDTH-1:0]      v_1,
  output logic [IO_DATA_WIDTH-1:0]      v_2,
  output logic [IO_DATA_WIDTH-1:0]      v_3,
  output logic [NB_BLOCKS-1:0]          LE_select,
  output logic                          cycle_enable,
  input  logic                          step_en,
`ifdef KDS_CTRL_RERUN_EN
  input  logic                          rerun,
`endif
  output logic [$clog2(FIFO_DEPTH)-1:0] step_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int BLK_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(FIFO_DEPTH - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(NB_BLOCKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [BLK_W-1:0] blk_cnt;
  logic [IDX_W-1:0] word_cnt;
  logic [15:0]      step_cnt;
  logic [15:0]      steps_lat;

  logic start_acc;
  logic rerun_acc;
  logic load_xfer;
  logic load_last;
  logic run_pending;
  logic run_step;
  logic run_finish;

  // The data path does not pass through the controller; these are plain copies.
  assign v_1 = k_data_1;
  assign v_2 = k_data_2;
  assign v_3 = k_data_3;

  assign start_acc   = (state == S_IDLE) && start;
  assign load_xfer   = (state == S_LOAD) && k_valid;
  assign load_last   = load_xfer && (blk_cnt == BLK_LAST) && (word_cnt == WORD_LAST);
  assign run_pending = (step_cnt != steps_lat);
  assign run_step    = (state == S_RUN) && step_en && run_pending;
  // Leave RUN right after the final step so that done follows that step by one
  // cycle; a zero-step job leaves on the first RUN cycle instead.
  assign run_finish  = (state == S_RUN) &&
                       (!run_pending || (run_step && ((step_cnt + 16'd1) == steps_lat)));

`ifdef KDS_CTRL_RERUN_EN
  logic kernel_loaded;

  // Start has priority; rerun needs a kernel left in the store by a completed LOAD.
  assign rerun_acc = (state == S_IDLE) && !start && rerun && kernel_loaded;

  // Track whether the store holds a complete kernel from the last LOAD.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      kernel_loaded <= 1'b0;
    end else if (start_acc) begin
      kernel_loaded <= 1'b0;
    end else if (load_last) begin
      kernel_loaded <= 1'b1;
    end else begin
      kernel_loaded <= kernel_loaded;
    end
  end
`else
  assign rerun_acc = 1'b0;
`endif

  assign k_ready      = (state == S_LOAD);
  assign cycle_enable = run_step;
  assign busy         = (state == S_LOAD) || (state == S_RUN);
  assign done         = (state == S_DONE);

  // One-hot write strobe for the block being filled, only on an actual transfer.
  always_comb begin
    LE_select = '0;
    if (load_xfer) begin
      LE_select[blk_cnt] = 1'b1;
    end else begin
      LE_select = '0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          state_nx = S_LOAD;
        end else if (rerun_acc) begin
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_last) begin
          state_nx = S_RUN;
        end else begin
          state_nx = S_LOAD;
        end
      end
      S_RUN: begin
        if (run_finish) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Load counters: word within a block, then block within the store.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      blk_cnt  <= '0;
      word_cnt <= '0;
    end else if (start_acc) begin
      blk_cnt  <= '0;
      word_cnt <= '0;
    end else if (load_xfer) begin
      if (word_cnt == WORD_LAST) begin
        word_cnt <= '0;
        blk_cnt  <= blk_cnt + BLK_W'(1);
      end else begin
        word_cnt <= word_cnt + IDX_W'(1);
        blk_cnt  <= blk_cnt;
      end
    end else begin
      blk_cnt  <= blk_cnt;
      word_cnt <= word_cnt;
    end
  end

  // Step budget and rotation position. A rerun keeps step_idx because the
  // FIFOs still sit at the position the previous run left them in.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      step_cnt  <= 16'd0;
      steps_lat <= 16'd0;
      step_idx  <= '0;
    end else if (start_acc) begin
      step_cnt  <= 16'd0;
      steps_lat <= nb_steps;
      step_idx  <= '0;
    end else if (rerun_acc) begin
      step_cnt  <= 16'd0;
      steps_lat <= nb_steps;
      step_idx  <= step_idx;
    end else if (run_step) begin
      step_cnt  <= step_cnt + 16'd1;
      steps_lat <= steps_lat;
      step_idx  <= step_idx + IDX_W'(1);
    end else begin
      step_cnt  <= step_cnt;
      steps_lat <= steps_lat;
      step_idx  <= step_idx;
    end
  end

endmodule

// File: doc/kds_ctrl.md
KDS_CTRL -- requirements
Module: kds_ctrl

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16, kernel word width.
REQ-002 SHALL have parameter NB_BLOCKS, default 12, number of 3-FIFO blocks in the kernel store.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per FIFO (power of two).
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port srst_in, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, begin a load-then-run job (sampled in IDLE only).
REQ-007 SHALL have port nb_steps, input, 16, rotation steps to run, latched on accepted start.
REQ-008 SHALL have ports k_data_1/k_data_2/k_data_3, input, IO_DATA_WIDTH each, kernel triplet.
REQ-009 SHALL have ports k_valid (input, 1) and k_ready (output, 1), triplet handshake.
REQ-010 SHALL have ports v_1/v_2/v_3, output, IO_DATA_WIDTH each, combinational copies of k_data_1..3.
REQ-011 SHALL have port LE_select, output, NB_BLOCKS, one-hot block write strobe.
REQ-012 SHALL have port cycle_enable, output, 1, rotate all FIFOs one entry.
REQ-013 SHALL have port step_en, input, 1, consumer permits one rotation this cycle.
REQ-014 SHALL have port step_idx, output, log2(FIFO_DEPTH), current rotation position.
REQ-015 SHALL have ports busy (output, 1, state is LOAD or RUN) and done (output, 1, one-cycle job-complete pulse).

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-017 IDLE: start=1 -> LOAD; latch nb_steps; clear blk_cnt, word_cnt, step_cnt, step_idx.
REQ-018 LOAD: k_ready=1; a transfer occurs when k_valid&&k_ready; LE_select[blk_cnt]=1 only in that cycle, else all zero.
REQ-019 LOAD: word_cnt increments per transfer; at FIFO_DEPTH-1 it wraps to 0 and blk_cnt increments.
REQ-020 LOAD: transfer with blk_cnt=NB_BLOCKS-1 and word_cnt=FIFO_DEPTH-1 -> RUN next cycle (96 transfers at defaults).
REQ-021 RUN: cycle_enable = step_en && (step_cnt != latched nb_steps); each such cycle increments step_cnt and step_idx (mod FIFO_DEPTH).
REQ-022 RUN: step_cnt == latched nb_steps -> DONE next cycle; nb_steps=0 gives RUN for one cycle with no cycle_enable.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 SHALL never assert cycle_enable and any LE_select bit in the same cycle; k_ready=0 outside LOAD.
REQ-025 start outside IDLE SHALL be ignored; k_valid outside LOAD SHALL be ignored with no LE_select.
REQ-026 Latency: first cycle_enable no earlier than the cycle after the last load transfer; done 1 cycle after the final step.

Reset
REQ-027 srst_in=1 at a clock edge SHALL force IDLE, all counters 0, LE_select=0, cycle_enable=0, k_ready=0, busy=0, done=0, step_idx=0.
REQ-028 Reset mid-LOAD or mid-RUN SHALL abandon the job; FIFO contents are not the controller's concern.

Configuration
REQ-029 Macro KDS_CTRL_RERUN_EN defined: add input rerun (1 bit) and internal kernel_loaded flag, set on LOAD->RUN, cleared by reset or accepted start.
REQ-030 With KDS_CTRL_RERUN_EN: in IDLE, rerun=1 && kernel_loaded && start=0 -> RUN with step_cnt=0, nb_steps relatched, step_idx retained; start has priority over rerun.
REQ-031 Without KDS_CTRL_RERUN_EN: no rerun port, no flag; RUN reachable only through LOAD.

Verification
REQ-032 Reset, start, 96 triplets with k_valid=1 continuously -> LE_select[0] for 8 cycles, then [1] ... [11]; RUN entered; no cycle_enable during LOAD.
REQ-033 k_valid toggled 1/0 during LOAD -> LE_select only on valid cycles; exactly 96 strobes total; busy stays 1.
REQ-034 nb_steps=10, step_en=1 -> 10 cycle_enable pulses, step_idx ends 2, done pulse 1 cycle later, then IDLE.
REQ-035 nb_steps=0 -> no cycle_enable; done asserted 2 cycles after last load transfer.
REQ-036 srst_in=1 after 40 load transfers -> next cycle IDLE, all outputs 0; subsequent start reloads from block 0.
REQ-037 With KDS_CTRL_RERUN_EN, after job with nb_steps=5: rerun=1, nb_steps=3 -> RUN without LOAD, 3 cycle_enable, step_idx 5->0; without kernel_loaded rerun is ignored.
